// File: rtl/secuenciador_instrucciones_if.sv
// Bus between the instruction sequencer and its driver: program load port,
// run control, and the instruction stream that feeds ISA.instruccion.
interface secuenciador_instrucciones_if #(
    parameter int ANCHO_DIR = 5
);
    // Stream semantics: `instruccion` is meaningful only while `valida` is high.
    // There is no ready/backpressure from ISA; the only stall is `pausa`,
    // which freezes the current word, the PC and the hold counter.
    logic                 carga_en;
    logic [ANCHO_DIR-1:0] carga_dir;
    logic [19:0]          carga_dato;
    logic                 inicio;
    logic                 pausa;
    logic [ANCHO_DIR:0]   largo;
    logic [19:0]          instruccion;
    logic                 valida;
    logic [ANCHO_DIR-1:0] pc;
    logic                 ocupado;
    logic                 fin;
    logic                 error_carga;
    logic [1:0]           estado_dbg;

    modport master (
        output carga_en, carga_dir, carga_dato, inicio, pausa, largo,
        input  instruccion, valida, pc, ocupado, fin, error_carga, estado_dbg
    );

    modport slave (
        input  carga_en, carga_dir, carga_dato, inicio, pausa, largo,
        output instruccion, valida, pc, ocupado, fin, error_carga, estado_dbg
    );
endinterface

// File: rtl/secuenciador_instrucciones.sv
// Instruction sequencer: loadable program memory that replays its words in
// order, holding each one RETENCION cycles on the ISA instruction input.
module secuenciador_instrucciones #(
    parameter int PROF      = 32,
    parameter int ANCHO_DIR = 5,
    parameter int RETENCION = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    secuenciador_instrucciones_if.slave  bus
);

    localparam int CW  = (RETENCION > 1) ? $clog2(RETENCION) : 1;
    localparam int AW1 = ANCHO_DIR + 1;
    localparam logic [CW-1:0]  CUENTA_INI = CW'(RETENCION - 1);
    localparam logic [AW1-1:0] PROF_W     = AW1'(PROF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMITIR = 2'd1,
        FIN    = 2'd2
    } estado_t;

    estado_t              r_estado;
    estado_t              w_estado_sig;
    logic [19:0]          r_mem [PROF];
    logic [ANCHO_DIR-1:0] r_pc;
    logic [ANCHO_DIR-1:0] w_pc_sig;
    logic [AW1-1:0]       r_restantes;
    logic [AW1-1:0]       w_restantes_sig;
    logic [CW-1:0]        r_cuenta;
    logic [CW-1:0]        w_cuenta_sig;
    logic                 r_error;
    logic                 w_escribe;
    logic                 w_rechazo;

    assign w_escribe = bus.carga_en && (r_estado == IDLE);
    assign w_rechazo = bus.carga_en && (r_estado != IDLE);

    // Program memory has no reset so a mid-run reset keeps the loaded program.
    always_ff @(posedge clk) begin
        if (w_escribe) begin
            r_mem[bus.carga_dir] <= bus.carga_dato;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado    <= IDLE;
            r_pc        <= '0;
            r_restantes <= '0;
            r_cuenta    <= '0;
            r_error     <= 1'b0;
        end else begin
            r_estado    <= w_estado_sig;
            r_pc        <= w_pc_sig;
            r_restantes <= w_restantes_sig;
            r_cuenta    <= w_cuenta_sig;
            r_error     <= w_rechazo;
        end
    end

    always_comb begin
        w_estado_sig    = r_estado;
        w_pc_sig        = r_pc;
        w_restantes_sig = r_restantes;
        w_cuenta_sig    = r_cuenta;
        case (r_estado)
            IDLE: begin
                // A load in the same cycle wins over a start request.
                if (bus.inicio && !bus.carga_en) begin
                    if (bus.largo == '0) begin
                        w_estado_sig = FIN;
                    end else begin
                        w_estado_sig    = EMITIR;
                        w_pc_sig        = '0;
                        w_cuenta_sig    = CUENTA_INI;
                        w_restantes_sig = (bus.largo > PROF_W) ? PROF_W : bus.largo;
                    end
                end
            end
            EMITIR: begin
                if (!bus.pausa) begin
                    if (r_cuenta != '0) begin
                        w_cuenta_sig = r_cuenta - CW'(1);
                    end else if (r_restantes > AW1'(1)) begin
                        w_pc_sig        = r_pc + ANCHO_DIR'(1);
                        w_restantes_sig = r_restantes - AW1'(1);
                        w_cuenta_sig    = CUENTA_INI;
                    end else begin
                        w_estado_sig = FIN;
                    end
                end
            end
            FIN: begin
                w_estado_sig = IDLE;
            end
            default: begin
                w_estado_sig = IDLE;
            end
        endcase
    end

    // Outside EMITIR the word is all zeros, so the RAM write-enable bit stays low.
    assign bus.instruccion = (r_estado == EMITIR) ? r_mem[r_pc] : 20'd0;
    assign bus.valida      = (r_estado == EMITIR);
    assign bus.pc          = r_pc;
    assign bus.ocupado     = (r_estado != IDLE);
    assign bus.fin         = (r_estado == FIN);
    assign bus.error_carga = r_error;
    assign bus.estado_dbg  = r_estado;

endmodule

// File: doc/secuenciador_instrucciones.md
# secuenciador_instrucciones

- Upstream instruction sequencer for the `ISA` datapath.
- Holds a small loadable program memory of 20-bit instruction words and a program counter.
- After a start pulse, it presents each instruction on its `instruccion` output in order, holding each word for a fixed number of cycles so the register bank, ALU and RAM downstream can settle and commit.
- Its `instruccion` output connects directly to `ISA.instruccion`.

## Interface

Parameters:
- `PROF`, 32 — program memory depth in words; must be a power of two.
- `ANCHO_DIR`, 5 — address width; log2(`PROF`).
- `RETENCION`, 4 — cycles each instruction is held on the output; must be ≥1.

Ports:
- Reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  — clock; all state changes on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `carga_en`  in  1  — write `carga_dato` into program memory at `carga_dir`.
- `carga_dir`  in  `ANCHO_DIR`  — program memory write address.
- `carga_dato`  in  20  — instruction word to store.
- `inicio`  in  1  — start execution from address 0; sampled only in IDLE.
- `pausa`  in  1  — freezes the hold counter and the PC while high.
- `largo`  in  `ANCHO_DIR`+1  — number of instructions to run; sampled at start.
- `instruccion`  out  20  — instruction word to `ISA`.
- `valida`  out  1  — `instruccion` carries a program word.
- `pc`  out  `ANCHO_DIR`  — address of the word currently presented.
- `ocupado`  out  1  — high in every state except IDLE.
- `fin`  out  1  — one-cycle pulse when a run completes.
- `error_carga`  out  1  — one-cycle pulse when `carga_en` arrives while busy.

## Operation

- **Memory**
  - `PROF` × 20-bit register array with combinational read.
  - Not cleared by reset.
  - Writes are accepted only in IDLE.
  - A `carga_en` while `ocupado`=1 is dropped, memory is unchanged, and `error_carga` pulses the next cycle.
- **States**
  - IDLE
    - `inicio`=1, `carga_en`=0, `largo`≠0: latch `min(largo, PROF)` into `restantes`, set `pc`=0, load `instruccion`=mem[0], `valida`=1, hold counter=`RETENCION`-1, go to EMITIR.
    - `inicio`=1, `largo`=0: go to FIN without asserting `valida`.
    - `inicio` and `carga_en` in the same cycle: the write commits and `inicio` is ignored (load has priority).
  - EMITIR
    - `pausa`=1: all state is frozen and `instruccion` holds.
    - Hold counter >0: decrement it.
    - Hold counter =0 and `restantes`>1: `pc`+1, `instruccion`=mem[`pc`+1], `restantes`-1, counter reloads to `RETENCION`-1.
    - Hold counter =0 and `restantes`=1: go to FIN.
  - FIN
    - Drive `instruccion`=0 and `valida`=0.
    - Assert `fin` for exactly this one cycle, then go to IDLE.
- **Idle output**
  - Outside EMITIR, `instruccion` is 20'b0: read RAM address 0, write-enable bit [0] low.
  - Bit [0] is therefore never high unless `valida`=1.
- **Other `inicio` handling:** `inicio` is ignored in EMITIR and FIN.
- **`pc` width:** `pc` wraps only via `largo` clamping; it never exceeds `PROF`-1.

## Timing

- **Reset values:** `instruccion`=0, `valida`=0, `pc`=0, `ocupado`=0, `fin`=0, `error_carga`=0; state IDLE.
- **Reset mid-run:** outputs return to reset values immediately (asynchronously). Memory contents are preserved.
- **Start latency:** `inicio` sampled high at edge N → `valida`=1 and `instruccion`=mem[0] after edge N.
- **Run length:** with no pause, each word is valid for exactly `RETENCION` cycles. A run of L words occupies L·`RETENCION` cycles of `valida`, followed by one `fin` cycle.
- **`ocupado` window:** `ocupado` rises together with `valida` (or with FIN when `largo`=0) and falls the cycle after `fin`.
- **Pause:** each cycle with `pausa`=1 in EMITIR extends the current word by exactly one cycle. `pausa` has no effect in IDLE or FIN.
- **Back-to-back runs:** a new `inicio` is accepted earliest in the cycle after `fin`.
- **`error_carga`:** asserts one cycle after the offending `carga_en` and repeats for each rejected write.

## Test plan

- **Load and run:**
  - Stimulus: load words 0..5 with 20'b00010_00111_0_010_00011_1, 20'b00000_00000_0_000_00011_0, 20'b01110_10010_0_000_10110_1, 20'b00010_11111_0_001_10001_1, 20'b00100_11000_0_110_11110_1, 20'b10000_11101_0_111_11011_1; then `largo`=6 and pulse `inicio`.
  - Response: each word appears in order for 4 cycles with `pc`=0..5, then `fin` pulses once at cycle 25 and `instruccion` returns to 0.
- **Pause:** hold `pausa` high for 3 cycles during word 2 → word 2 stays valid for 7 cycles, `pc`=2 throughout, and `fin` is delayed by 3 cycles.
- **Zero and clamped lengths:**
  - `largo`=0 → `fin` the cycle after `inicio`, `valida` never asserts.
  - `largo`=40 → 32 words run, `pc` ends at 31.
- **Load while busy:**
  - `carga_en` at address 1 in cycle 3 of a run → `error_carga` pulses once.
  - A rerun shows the original word at address 1.
- **Simultaneous load and start:** `carga_en` and `inicio` in the same IDLE cycle → write commits, `ocupado` stays 0; a following `inicio` runs with the new word.
- **Reset mid-run:** assert `rst` during word 3 → all outputs go to 0 immediately; a rerun after release reproduces the loaded program unchanged.
